// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out transmitter, MSB- or LSB-first per word.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_out_last
);
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;
    logic             r_out;
    logic [WIDTH-1:0] w_next;
    logic             w_bit;
    logic             w_accept;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             r_par;
`endif
    assign o_out_valid = r_state == SHIFT;
    assign o_out_last  = o_out_valid && r_cnt == CW'(FRAME - 1);
    assign o_in_ready  = i_rst && (!o_out_valid || o_out_last);
    assign o_out       = r_out;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_next      = r_dir ? r_sreg << 1 : r_sreg >> 1;
`ifdef PISO_SERIALIZER_PARITY_EN
    // Parity trails the data bits whatever the shift direction.
    assign w_bit = r_cnt == CW'(WIDTH - 1) ? r_par : (r_dir ? w_next[WIDTH-1] : w_next[0]);
`else
    assign w_bit = r_dir ? w_next[WIDTH-1] : w_next[0];
`endif
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_out   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_sreg  <= i_in_data;
            r_cnt   <= '0;
            r_dir   <= i_mode;
            r_out   <= i_mode ? i_in_data[WIDTH-1] : i_in_data[0];
`ifdef PISO_SERIALIZER_PARITY_EN
            r_par   <= ^i_in_data;
`endif
        end else if (o_out_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else if (o_out_valid) begin
            r_sreg  <= w_next;
            r_cnt   <= r_cnt + CW'(1);
            r_out   <= w_bit;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed stimulus against a queue-based frame model checked every cycle,
// plus literal bit-sequence expectations for each scenario.
module tb_piso_serializer;
    localparam int WIDTH = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam logic [31:0] L_B4M = 32'b101101000;
    localparam logic [31:0] L_B4L = 32'b001011010;
    localparam logic [31:0] L_07L = 32'b111000001;
    localparam logic [31:0] L_B2B = 32'b101101000111100000;
    localparam logic [31:0] L_81L = 32'b100000010;
    localparam logic [31:0] L_FFM = 32'b111111110;
    localparam logic [31:0] L_01M = 32'b000000011;
`else
    localparam int FRAME = WIDTH;
    localparam logic [31:0] L_B4M = 32'b10110100;
    localparam logic [31:0] L_B4L = 32'b00101101;
    localparam logic [31:0] L_07L = 32'b11100000;
    localparam logic [31:0] L_B2B = 32'b1011010011110000;
    localparam logic [31:0] L_81L = 32'b10000001;
    localparam logic [31:0] L_FFM = 32'b11111111;
    localparam logic [31:0] L_01M = 32'b00000001;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mode = 1'b0;
    logic in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic in_ready, out, out_valid, out_last;
    int nchk = 0;
    int npass = 0;
    typedef struct {logic b; logic l;} ent_t;
    ent_t q[$];
    logic seen[$];
    logic m_acc;
    logic [31:0] m_v;
    ent_t m_e;
    logic e_v, e_b, e_l, e_r;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_out(out), .o_out_valid(out_valid), .o_out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Frame bits in transmission order, first bit in the most significant used position.
    function automatic logic [31:0] model_vec(input logic [WIDTH-1:0] d, input logic m);
        logic [31:0] v = '0;
        for (int i = 0; i < WIDTH; i++) v = {v[30:0], m ? d[WIDTH-1-i] : d[i]};
`ifdef PISO_SERIALIZER_PARITY_EN
        v = {v[30:0], ^d};
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst) q.delete();
        else begin
            m_acc = in_valid && (q.size() == 0 || q[0].l);
            m_v = model_vec(in_data, mode);
            if (q.size() > 0) void'(q.pop_front());
            if (m_acc)
                for (int i = 0; i < FRAME; i++) begin
                    m_e.b = m_v[FRAME-1-i];
                    m_e.l = (i == FRAME - 1);
                    q.push_back(m_e);
                end
        end
    end

    always @(negedge clk) begin
        e_v = q.size() > 0;
        e_b = e_v ? q[0].b : 1'b0;
        e_l = e_v ? q[0].l : 1'b0;
        e_r = rst && (!e_v || e_l);
        chk("out_valid", out_valid, e_v);
        chk("out", out, e_b);
        chk("out_last", out_last, e_l);
        chk("in_ready", in_ready, e_r);
        if (out_valid) seen.push_back(out);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic m);
        in_data = d;
        mode = m;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                tick();
                return;
            end
            tick();
        end
        chk("accept_timeout", in_ready, 1);
    endtask

    task automatic expect_seq(input string nm, input logic [31:0] exp, input int n);
        logic [31:0] v = '0;
        foreach (seen[i]) v = {v[30:0], seen[i]};
        chk({nm, "_len"}, seen.size(), n);
        chk(nm, v, exp);
    endtask

    task automatic one(input string nm, input logic [WIDTH-1:0] d, input logic m, input logic [31:0] exp);
        seen.delete();
        send(d, m);
        in_valid = 1'b0;
        repeat (FRAME + 2) tick();
        expect_seq(nm, exp, FRAME);
    endtask

    initial begin
        chk("model_b4_msb", model_vec(8'hB4, 1'b1), L_B4M);
        chk("model_07_lsb", model_vec(8'h07, 1'b0), L_07L);
        in_valid = 1'b1;
        in_data = 8'hB4;
        mode = 1'b1;
        repeat (3) tick();
        chk("rst_no_accept", seen.size(), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        one("b4_msb", 8'hB4, 1'b1, L_B4M);
        one("b4_lsb", 8'hB4, 1'b0, L_B4L);
        one("07_lsb", 8'h07, 1'b0, L_07L);
        one("81_lsb", 8'h81, 1'b0, L_81L);
        one("ff_msb", 8'hFF, 1'b1, L_FFM);
        one("01_msb", 8'h01, 1'b1, L_01M);
        seen.delete();
        send(8'hB4, 1'b1);
        send(8'h0F, 1'b0);
        in_valid = 1'b0;
        repeat (FRAME + 2) tick();
        expect_seq("back2back", L_B2B, 2 * FRAME);
        seen.delete();
        send(8'hB4, 1'b1);
        in_valid = 1'b0;
        repeat (2) tick();
        mode = 1'b0;
        in_data = 8'h5A;
        repeat (FRAME) tick();
        expect_seq("mode_flip", L_B4M, FRAME);
        seen.delete();
        send(8'hB4, 1'b1);
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        expect_seq("rst_mid", 32'b101, 3);
        one("after_rst", 8'hB4, 1'b1, L_B4M);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that drives the serial input of the team's bidirectional shift registers. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock, MSB-first or LSB-first, selected by `mode`. It sits upstream of a shift-register receiver, and its `mode` encoding matches the receiver's: 1 = left shift / MSB-first, 0 = right shift / LSB-first.

## Interface
- `WIDTH`, default 8: data word width, ≥ 2.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `mode` input 1: bit order. 1 = MSB-first, 0 = LSB-first. Sampled only at word accept.
- `in_data` input WIDTH: parallel word to transmit.
- `in_valid` input 1: `in_data` and `mode` are valid.
- `in_ready` output 1: block can accept a word this cycle.
- `out` output 1: serial data bit, registered.
- `out_valid` output 1: `out` carries a frame bit this cycle.
- `out_last` output 1: this is the final bit of the current frame.

## Operation
- FRAME = WIDTH, or WIDTH+1 with parity enabled.
- Two-state FSM:
  - IDLE: `out_valid`=0, `out`=0, `out_last`=0.
  - SHIFT: one frame bit per cycle.
- Internal state:
  - shift register `sreg[WIDTH-1:0]`
  - bit counter `cnt`, range 0..FRAME-1, width $clog2(FRAME)
  - latched order bit `dir`
  - parity accumulator, only when parity is enabled
- Handshake:
  - Accept occurs when `in_valid && in_ready` at a rising edge.
  - `in_ready` is combinational: `rst && (state==IDLE || (state==SHIFT && out_last))`.
  - Accept is therefore allowed in IDLE and on the last-bit cycle, which gives back-to-back frames with no gap.
- On accept:
  - `sreg` ← `in_data`, `dir` ← `mode`, `cnt` ← 0.
  - State becomes SHIFT.
  - `out` ← `in_data[WIDTH-1]` if `mode`=1, else `in_data[0]`.
- Each subsequent SHIFT cycle:
  - `sreg` shifts left (`dir`=1) or right (`dir`=0) and `cnt` increments.
  - `out` takes the next bit in the latched order.
- `out_last` = 1 when `cnt`==FRAME-1.
- After the last bit:
  - With an accept on that cycle, the new frame's first bit follows immediately.
  - Without an accept, state returns to IDLE and `out_valid` drops.
- `mode` and `in_data` changes outside the accept cycle have no effect on the frame in flight.
- `in_valid` held while `in_ready`=0: the word is not consumed. The producer holds `in_data` until accepted.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, `out`=0, `out_valid`=0, `out_last`=0, `cnt`=0, `sreg`=0. `in_ready`=0 while `rst`=0.
- Reset mid-frame aborts the frame immediately. No partial bits are emitted after the reset edge.
- Latency: the first bit is visible on `out` in the cycle after the accept edge.
- A frame occupies exactly FRAME consecutive cycles with `out_valid`=1.
- Sustained throughput: one word per FRAME cycles.

## Configuration
- Macro `PISO_SERIALIZER_PARITY_EN`.
- Defined:
  - FRAME = WIDTH+1.
  - The extra final bit is even parity (XOR of all WIDTH data bits), emitted after the data bits regardless of `dir`.
  - `out_last` is asserted on the parity bit.
- Undefined:
  - FRAME = WIDTH.
  - No parity logic is synthesized.
  - `out_last` is asserted on the final data bit.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out`=0, `out_valid`=0, `out_last`=0 throughout. No accept occurs.
- MSB-first, WIDTH=8, no parity: accept 0xB4 with `mode`=1 → `out` = 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting one cycle after accept. `out_last`=1 only on the 8th bit. `out_valid`=0 on the next cycle.
- LSB-first: accept 0xB4 with `mode`=0 → `out` = 0,0,1,0,1,1,0,1.
- Back-to-back: keep `in_valid`=1 and present 0xB4 (`mode`=1), then 0x0F (`mode`=0) → 16 contiguous `out_valid` cycles: 1,0,1,1,0,1,0,0,1,1,1,1,0,0,0,0. `in_ready`=1 only on the cycle each word is accepted.
- Mode toggle / reset mid-frame:
  - Accept 0xB4 with `mode`=1, then flip `mode` to 0 after 2 bits → sequence unchanged from the MSB-first case.
  - Assert `rst`=0 after 3 bits → next cycle `out_valid`=0, `out`=0. After release, a new accept of 0xB4 restarts from bit 1.
- Parity (macro defined): 0xB4 MSB-first → 9 bits ending in 0. 0x07 LSB-first → 1,1,1,0,0,0,0,0 then 1. `out_last` on bit 9 only.
